// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the two-master SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_BLOCK  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Controller dqm masks a byte with 1, the opposite sense of a write strobe.
  function automatic logic [3:0] wstrb_to_dqm(input logic [3:0] wstrb);
    return ~wstrb;
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational 2-way grant selection: round-robin or fixed priority (master 0 first).
module sdram_rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |valid;
    grant_idx   = M0;
    if (valid == 2'b10) begin
      grant_idx = M1;
    end else if (valid == 2'b11) begin
      grant_idx = (PRIORITY_MODE != 0) ? M0 : ~last_grant;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master valid/ready arbiter for the single-outstanding SDRAM command port.
// Commands are held for a full controller cycle; idle gaps are forced for refresh.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int PRIORITY_MODE    = 0,
  parameter int REFRESH_INTERVAL = 600,
  parameter int REFRESH_GAP      = 34,
  parameter int ADDR_W           = 26
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_wstrb,
  input  logic [31:0]       m0_wdata,
  output logic [31:0]       m0_rdata,
  output logic              m0_ready,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_wstrb,
  input  logic [31:0]       m1_wdata,
  output logic [31:0]       m1_rdata,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [3:0]        ram_dqm,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic              ram_ready,
  output logic              busy
);

  localparam int RW = $clog2(REFRESH_INTERVAL + 1);
  localparam int GW = $clog2(REFRESH_GAP + 1);
  localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_INTERVAL);
  localparam logic [GW-1:0] GAP_LAST = GW'(REFRESH_GAP - 1);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic [RW-1:0]     refresh_cnt_q, refresh_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              ram_ready_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_oe_q, ram_oe_d;
  logic [3:0]        ram_dqm_q, ram_dqm_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic              m0_ready_q, m0_ready_d;
  logic              m1_ready_q, m1_ready_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d;
  logic [31:0]       m1_rdata_q, m1_rdata_d;

  logic              grant_valid;
  logic              grant_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_wstrb;
  logic [31:0]       sel_wdata;
  logic              ready_rise;

  sdram_rr_pick #(
    .PRIORITY_MODE(PRIORITY_MODE)
  ) u_pick (
    .valid      ({m1_valid, m0_valid}),
    .last_grant (last_grant_q),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  assign sel_addr   = (grant_idx == M1) ? m1_addr  : m0_addr;
  assign sel_wstrb  = (grant_idx == M1) ? m1_wstrb : m0_wstrb;
  assign sel_wdata  = (grant_idx == M1) ? m1_wdata : m0_wdata;
  // A level already high when ACCESS starts belongs to the previous cycle.
  assign ready_rise = ram_ready & ~ram_ready_q;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    refresh_cnt_d = (refresh_cnt_q >= REF_MAX) ? refresh_cnt_q : refresh_cnt_q + RW'(1);
    gap_cnt_d     = '0;
    ram_addr_d    = ram_addr_q;
    ram_we_d      = ram_we_q;
    ram_oe_d      = ram_oe_q;
    ram_dqm_d     = ram_dqm_q;
    ram_din_d     = ram_din_q;
    m0_ready_d    = 1'b0;
    m1_ready_d    = 1'b0;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;

    unique case (state_q)
      ST_BLOCK: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d       = ST_IDLE;
          refresh_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      ST_IDLE: begin
        if (refresh_cnt_q >= REF_MAX) begin
          state_d = ST_BLOCK;
        end else if (grant_valid) begin
          ram_addr_d   = sel_addr;
          ram_dqm_d    = wstrb_to_dqm(sel_wstrb);
          ram_din_d    = sel_wdata;
          ram_we_d     = |sel_wstrb;
          ram_oe_d     = ~|sel_wstrb;
          last_grant_d = grant_idx;
          grant_d      = grant_idx;
          state_d      = ST_ACCESS;
        end else if (gap_cnt_q == GAP_LAST) begin
          // Enough natural idle time for the controller to have refreshed.
          refresh_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      ST_ACCESS: begin
        if (ready_rise) begin
          ram_we_d = 1'b0;
          ram_oe_d = 1'b0;
          if (grant_q == M1) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = ram_dout;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = ram_dout;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_BLOCK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_BLOCK;
      last_grant_q  <= M1;
      grant_q       <= M0;
      refresh_cnt_q <= '0;
      gap_cnt_q     <= '0;
      ram_ready_q   <= 1'b0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_oe_q      <= 1'b0;
      ram_dqm_q     <= 4'hF;
      ram_din_q     <= '0;
      m0_ready_q    <= 1'b0;
      m1_ready_q    <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      refresh_cnt_q <= refresh_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      ram_ready_q   <= ram_ready;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_oe_q      <= ram_oe_d;
      ram_dqm_q     <= ram_dqm_d;
      ram_din_q     <= ram_din_d;
      m0_ready_q    <= m0_ready_d;
      m1_ready_q    <= m1_ready_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_we   = ram_we_q;
  assign ram_oe   = ram_oe_q;
  assign ram_dqm  = ram_dqm_q;
  assign ram_din  = ram_din_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench: two arbiter instances (round-robin and fixed priority), each
// with its own SDRAM controller model backed by a small memory.
module tb_sdram_arbiter;

  localparam int AW = 26;
  localparam int RI = 600;
  localparam int RG = 34;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [3:0]    dqm;
    logic [31:0]   din;
    logic [31:0]   rdata;
  } txn_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic          oe;
    logic [3:0]    dqm;
    logic [31:0]   din;
    bit            stable;
  } cmd_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          mv   [2][2];
  logic [AW-1:0] ma   [2][2];
  logic [3:0]    mw   [2][2];
  logic [31:0]   md   [2][2];
  logic [31:0]   mr   [2][2];
  logic          mrdy [2][2];
  logic [AW-1:0] ram_addr  [2];
  logic          ram_we    [2];
  logic          ram_oe    [2];
  logic [3:0]    ram_dqm   [2];
  logic [31:0]   ram_din   [2];
  logic [31:0]   ram_dout  [2];
  logic          ram_ready [2];
  logic          busy      [2];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  txn_t        sbq [4][$];
  cmd_t        lcmd [2];
  logic [31:0] cmem [2][32];
  logic [31:0] smem [2][32];
  logic [31:0] last_rd [2][2];
  bit          auto_on [2][2];
  bit          cont;
  bit          rec_on;
  bit          ref_on;
  int          gseq [2][$];
  int          lat_fix;
  int          hold_fix;
  int          run [2];
  int          win [2];
  int          lastw [2];
  int          maxsp [2];

  always #5 clk = ~clk;

  sdram_arbiter #(.PRIORITY_MODE(0), .REFRESH_INTERVAL(RI), .REFRESH_GAP(RG), .ADDR_W(AW)) u_rr (
    .clk(clk), .resetn(resetn),
    .m0_valid(mv[0][0]), .m0_addr(ma[0][0]), .m0_wstrb(mw[0][0]), .m0_wdata(md[0][0]),
    .m0_rdata(mr[0][0]), .m0_ready(mrdy[0][0]),
    .m1_valid(mv[0][1]), .m1_addr(ma[0][1]), .m1_wstrb(mw[0][1]), .m1_wdata(md[0][1]),
    .m1_rdata(mr[0][1]), .m1_ready(mrdy[0][1]),
    .ram_addr(ram_addr[0]), .ram_we(ram_we[0]), .ram_oe(ram_oe[0]), .ram_dqm(ram_dqm[0]),
    .ram_din(ram_din[0]), .ram_dout(ram_dout[0]), .ram_ready(ram_ready[0]), .busy(busy[0])
  );

  sdram_arbiter #(.PRIORITY_MODE(1), .REFRESH_INTERVAL(RI), .REFRESH_GAP(RG), .ADDR_W(AW)) u_fp (
    .clk(clk), .resetn(resetn),
    .m0_valid(mv[1][0]), .m0_addr(ma[1][0]), .m0_wstrb(mw[1][0]), .m0_wdata(md[1][0]),
    .m0_rdata(mr[1][0]), .m0_ready(mrdy[1][0]),
    .m1_valid(mv[1][1]), .m1_addr(ma[1][1]), .m1_wstrb(mw[1][1]), .m1_wdata(md[1][1]),
    .m1_rdata(mr[1][1]), .m1_ready(mrdy[1][1]),
    .ram_addr(ram_addr[1]), .ram_we(ram_we[1]), .ram_oe(ram_oe[1]), .ram_dqm(ram_dqm[1]),
    .ram_din(ram_din[1]), .ram_dout(ram_dout[1]), .ram_ready(ram_ready[1]), .busy(busy[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Each master owns its own 16-word region (addr bit 6 = master index), so the
  // reference memory outcome is independent of grant order between masters.
  task automatic issue(input int k, input int m, input logic [AW-1:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    txn_t t;
    int   idx;
    idx = int'(a[6:2]);
    for (int b = 0; b < 4; b++) if (s[b]) smem[k][idx][8*b +: 8] = d[8*b +: 8];
    t.addr  = a;
    t.we    = |s;
    t.dqm   = ~s;
    t.din   = d;
    t.rdata = smem[k][idx];
    sbq[k*2+m].push_back(t);
    ma[k][m] = a;
    mw[k][m] = s;
    md[k][m] = d;
    mv[k][m] = 1'b1;
  endtask

  task automatic issue_rand(input int k, input int m);
    logic [18:0]   hi;
    logic [3:0]    w;
    logic [3:0]    s;
    logic [AW-1:0] a;
    hi = 19'($urandom);
    w  = 4'($urandom);
    s  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    a  = {hi, (m == 1), w, 2'b00};
    issue(k, m, a, s, $urandom);
  endtask

  task automatic drain(input int budget);
    int  c;
    bit  done;
    c    = 0;
    done = 1'b0;
    while (!done && c < budget) begin
      done = 1'b1;
      for (int q = 0; q < 4; q++) if (sbq[q].size() != 0 || mv[q/2][q%2]) done = 1'b0;
      if (!done) begin
        @(negedge clk);
        c++;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: requests still pending after %0d cycles, required none", budget);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SDRAM controller model: latency, then ready held high for a few cycles.
  initial begin : ctl_model
    cmd_t snap [2];
    int   lat [2];
    int   hold_left [2];
    bit   act [2];
    bit   wait_drop [2];
    int   idx;
    logic cmd;
    for (int k = 0; k < 2; k++) begin
      lat[k] = 0; hold_left[k] = 0; act[k] = 1'b0; wait_drop[k] = 1'b0;
      ram_ready[k] = 1'b0; ram_dout[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        cmd = ram_oe[k] | ram_we[k];
        if (wait_drop[k] && !cmd) wait_drop[k] = 1'b0;
        if (act[k]) begin
          if (ram_addr[k] !== snap[k].addr || ram_we[k] !== snap[k].we || ram_oe[k] !== snap[k].oe ||
              ram_dqm[k] !== snap[k].dqm || ram_din[k] !== snap[k].din) snap[k].stable = 1'b0;
          if (lat[k] == 0) begin
            idx = int'(snap[k].addr[6:2]);
            if (snap[k].we)
              for (int b = 0; b < 4; b++)
                if (!snap[k].dqm[b]) cmem[k][idx][8*b +: 8] = snap[k].din[8*b +: 8];
            ram_dout[k]  = cmem[k][idx];
            lcmd[k]      = snap[k];
            hold_left[k] = (hold_fix > 0) ? hold_fix : int'($urandom_range(1, 6));
            act[k]       = 1'b0;
            wait_drop[k] = 1'b1;
          end else begin
            lat[k]--;
          end
        end else if (cmd && !wait_drop[k] && hold_left[k] == 0) begin
          act[k]          = 1'b1;
          snap[k].addr    = ram_addr[k];
          snap[k].we      = ram_we[k];
          snap[k].oe      = ram_oe[k];
          snap[k].dqm     = ram_dqm[k];
          snap[k].din     = ram_din[k];
          snap[k].stable  = 1'b1;
          lat[k]          = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
        end
        if (hold_left[k] > 0) begin
          ram_ready[k] = 1'b1;
          hold_left[k]--;
        end else begin
          ram_ready[k] = 1'b0;
        end
      end
    end
  end

  initial begin : driver
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        for (int m = 0; m < 2; m++) begin
          if (mrdy[k][m]) mv[k][m] = 1'b0;
          if (auto_on[k][m] && !mv[k][m] && (cont || $urandom_range(0, 2) == 0)) issue_rand(k, m);
        end
    end
  end

  initial begin : monitor
    txn_t t;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        for (int m = 0; m < 2; m++)
          if (mrdy[k][m]) begin
            if (sbq[k*2+m].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_ready i%0d m%0d: ready pulse with no pending request, required none", k, m);
            end else begin
              t = sbq[k*2+m].pop_front();
              chk($sformatf("rdata i%0d m%0d", k, m), mr[k][m], t.rdata);
              chk($sformatf("ram_addr i%0d m%0d", k, m), lcmd[k].addr, t.addr);
              chk($sformatf("ram_we i%0d m%0d", k, m), lcmd[k].we, t.we);
              chk($sformatf("ram_oe i%0d m%0d", k, m), lcmd[k].oe, !t.we);
              chk($sformatf("ram_dqm i%0d m%0d", k, m), lcmd[k].dqm, t.dqm);
              chk($sformatf("ram_din i%0d m%0d", k, m), lcmd[k].din, t.din);
              chk($sformatf("cmd_stable i%0d m%0d", k, m), lcmd[k].stable, 1);
              if (rec_on) gseq[k].push_back(m);
            end
            chk($sformatf("other_rdata i%0d m%0d", k, 1 - m), mr[k][1-m], last_rd[k][1-m]);
            last_rd[k][m] = mr[k][m];
          end
    end
  end

  initial begin : refresh_mon
    forever begin
      @(negedge clk);
      if (ref_on)
        for (int k = 0; k < 2; k++) begin
          if (!ram_oe[k] && !ram_we[k]) begin
            run[k]++;
            if (run[k] == RG) begin
              win[k]++;
              if (win[k] > 1 && cyc - lastw[k] > maxsp[k]) maxsp[k] = cyc - lastw[k];
              lastw[k] = cyc;
            end
          end else begin
            run[k] = 0;
          end
        end
    end
  end

  initial begin : main
    int c;
    int m1cnt;
    int bad;
    resetn   = 1'b0;
    cont     = 1'b0;
    rec_on   = 1'b0;
    ref_on   = 1'b0;
    lat_fix  = 1;
    hold_fix = 2;
    for (int k = 0; k < 2; k++) begin
      run[k] = 0; win[k] = 0; lastw[k] = 0; maxsp[k] = 0;
      for (int i = 0; i < 32; i++) begin
        cmem[k][i] = 32'h5A00_0000 + 32'(i * 32'h0101_0101);
        smem[k][i] = cmem[k][i];
      end
      cmem[k][0] = 32'h1122_3344;
      smem[k][0] = 32'h1122_3344;
      for (int m = 0; m < 2; m++) begin
        mv[k][m] = 1'b0; ma[k][m] = '0; mw[k][m] = '0; md[k][m] = '0;
        last_rd[k][m] = '0; auto_on[k][m] = 1'b0;
      end
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst ram_oe i%0d", k), ram_oe[k], 0);
      chk($sformatf("rst ram_we i%0d", k), ram_we[k], 0);
      chk($sformatf("rst ram_addr i%0d", k), ram_addr[k], 0);
      chk($sformatf("rst ram_dqm i%0d", k), ram_dqm[k], 4'hF);
      chk($sformatf("rst ram_din i%0d", k), ram_din[k], 0);
      chk($sformatf("rst ready i%0d", k), {mrdy[k][1], mrdy[k][0]}, 0);
      chk($sformatf("rst rdata i%0d", k), {mr[k][1], mr[k][0]}, 0);
      chk($sformatf("rst busy i%0d", k), busy[k], 1);
    end

    // First read must wait out the post-reset BLOCK window
    for (int k = 0; k < 2; k++) issue(k, 0, 26'h000100, 4'h0, 32'h0);
    resetn = 1'b1;
    c = 0;
    while (!ram_oe[0] && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("first_oe_after_gap", (c > RG), 1);
    chk("first_oe_not_late", (c <= RG + 2), 1);
    chk("first_addr", ram_addr[0], 26'h000100);
    chk("first_oe_fp", ram_oe[1], 1);
    drain(200);

    // Partial write from master 1
    for (int k = 0; k < 2; k++) issue(k, 1, 26'h000140, 4'b0011, 32'hAABB_CCDD);
    c = 0;
    while (!ram_we[0] && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("wr ram_we", ram_we[0], 1);
    chk("wr ram_oe", ram_oe[0], 0);
    chk("wr ram_dqm", ram_dqm[0], 4'b1100);
    chk("wr ram_din", ram_din[0], 32'hAABB_CCDD);
    drain(200);

    // Saturation: both masters continuously requesting
    @(negedge clk);
    cont   = 1'b1;
    rec_on = 1'b1;
    for (int k = 0; k < 2; k++) begin auto_on[k][0] = 1'b1; auto_on[k][1] = 1'b1; end
    repeat (300) @(negedge clk);
    rec_on = 1'b0;
    for (int k = 0; k < 2; k++) begin auto_on[k][0] = 1'b0; auto_on[k][1] = 1'b0; end
    drain(1000);
    chk("rr_grant_count", (gseq[0].size() >= 8), 1);
    for (int i = 1; i < gseq[0].size(); i++)
      chk($sformatf("rr_alternate %0d", i), (gseq[0][i] != gseq[0][i-1]), 1);
    m1cnt = 0;
    foreach (gseq[1][i]) if (gseq[1][i] == 1) m1cnt++;
    chk("fp_grant_count", (gseq[1].size() >= 8), 1);
    chk("fp_m1_starved", m1cnt, 0);

    // Sustained master 0 traffic must still see periodic refresh windows
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin run[k] = 0; win[k] = 0; maxsp[k] = 0; auto_on[k][0] = 1'b1; end
    ref_on = 1'b1;
    repeat (2400) @(negedge clk);
    ref_on = 1'b0;
    for (int k = 0; k < 2; k++) auto_on[k][0] = 1'b0;
    drain(500);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("refresh_windows i%0d", k), (win[k] >= 3), 1);
      chk($sformatf("refresh_spacing i%0d", k), (maxsp[k] <= RI + RG + 60), 1);
    end
    cont = 1'b0;

    // Reset in the middle of an access; the stale ready must be ignored
    lat_fix = 5;
    for (int k = 0; k < 2; k++) begin
      ma[k][0] = 26'h000104; mw[k][0] = 4'h0; md[k][0] = '0; mv[k][0] = 1'b1;
    end
    c = 0;
    while (!(ram_oe[0] && ram_oe[1]) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("midrst_access_reached", (ram_oe[0] && ram_oe[1]), 1);
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin mv[k][0] = 1'b0; mv[k][1] = 1'b0; end
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin last_rd[k][0] = '0; last_rd[k][1] = '0; end
    chk("midrst ram_oe", ram_oe[0], 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) for (int m = 0; m < 2; m++) if (mrdy[k][m]) bad++;
    end
    chk("midrst_no_ready", bad, 0);
    lat_fix = 0;
    for (int k = 0; k < 2; k++) issue(k, 0, 26'h000108, 4'h0, 32'h0);
    drain(200);

    // Ready still high from the previous transfer when the next ACCESS starts
    lat_fix  = 1;
    hold_fix = 7;
    @(negedge clk);
    cont = 1'b1;
    for (int k = 0; k < 2; k++) begin auto_on[k][0] = 1'b1; auto_on[k][1] = 1'b1; end
    repeat (150) @(negedge clk);
    for (int k = 0; k < 2; k++) begin auto_on[k][0] = 1'b0; auto_on[k][1] = 1'b0; end
    drain(1000);
    cont = 1'b0;

    // Random mixed traffic
    lat_fix  = 0;
    hold_fix = 0;
    for (int k = 0; k < 2; k++) begin auto_on[k][0] = 1'b1; auto_on[k][1] = 1'b1; end
    repeat (1500) @(negedge clk);
    for (int k = 0; k < 2; k++) begin auto_on[k][0] = 1'b0; auto_on[k][1] = 1'b0; end
    drain(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Two-master arbiter in front of the picosoc SDRAM controller. It shares the 32-bit, single-outstanding SDRAM command port between master 0 (the CPU memory bus) and master 1 (a DMA or video fetch engine), both using picorv32-style valid/ready. It holds each command stable for one full SDRAM cycle and detects completion on the rising edge of the controller's ready. It also forces idle gaps so the controller issues auto-refresh under sustained traffic.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin between masters; 1 = fixed priority, master 0 wins.
REFRESH_INTERVAL, 600, clk cycles between forced refresh gaps (~7 us at 86 MHz).
REFRESH_GAP, 34, clk cycles with oe=we=0 needed to guarantee one SDRAM idle (refresh) slot, including clkref sync slack.
ADDR_W, 26, byte address width.

Ports:
clk  in  1  SDRAM-domain clock
resetn  in  1  synchronous active-low reset
m0_valid  in  1  master 0 request; held until m0_ready
m0_addr  in  ADDR_W  master 0 byte address (bits [1:0] ignored)
m0_wstrb  in  4  byte write strobes; 0 means read
m0_wdata  in  32  master 0 write data
m0_rdata  out  32  master 0 read data, valid while m0_ready=1
m0_ready  out  1  one-cycle completion pulse
m1_valid, m1_addr, m1_wstrb, m1_wdata, m1_rdata, m1_ready  same as master 0, for master 1
ram_addr  out  ADDR_W  to controller addr
ram_we  out  1  to controller we
ram_oe  out  1  to controller oeA
ram_dqm  out  4  to controller dqm; equals ~wstrb, where 1 masks a byte
ram_din  out  32  to controller din
ram_dout  in  32  from controller dout
ram_ready  in  1  from controller ready (multi-cycle level)
busy  out  1  1 whenever state is not IDLE

Behaviour:
- Reset (resetn=0 at posedge clk):
  - state=BLOCK, ram_we=ram_oe=0, ram_addr=0, ram_dqm=4'hF, ram_din=0.
  - m0_ready=m1_ready=0; m0_rdata=m1_rdata=0.
  - last_grant=1, so master 0 wins the first tie.
  - refresh and gap counters = 0.
- States: BLOCK, IDLE, ACCESS, DONE.
- BLOCK:
  - ram_oe=ram_we=0 for REFRESH_GAP cycles, then IDLE.
  - Entered after reset, so a stale controller cycle left over from a mid-access reset drains without being mistaken for completion.
  - Also entered for refresh.
- IDLE:
  - If refresh_cnt >= REFRESH_INTERVAL, go to BLOCK. Refresh has priority over pending requests.
  - Otherwise, if any valid is high, pick a winner.
    - Round-robin: the master not equal to last_grant wins a tie.
    - Fixed mode: master 0 wins a tie.
  - Latch the winner's addr/wstrb/wdata into the ram_* registers.
  - ram_we=|wstrb; ram_oe=~|wstrb.
  - Set last_grant; go to ACCESS.
  - The ram_* outputs change only on this transition.
- ACCESS:
  - Hold ram_* stable.
  - Completion is ram_ready & ~ram_ready_q, where ram_ready_q is ram_ready delayed one cycle.
  - On completion: capture ram_dout into the granted master's rdata; pulse that master's ready for exactly one cycle; drop ram_we/ram_oe in the same edge; go to DONE.
- DONE:
  - One cycle, so the master can drop valid.
  - Then IDLE.
  - Minimum back-to-back issue spacing is 2 clk after a ready pulse.
- Refresh accounting:
  - refresh_cnt increments every cycle, saturating at REFRESH_INTERVAL.
  - It clears when BLOCK completes.
  - It also clears when IDLE with no valid persists for REFRESH_GAP consecutive cycles (natural refresh).
- Other boundary rules:
  - A valid that drops before grant is ignored.
  - The non-granted master's valid is held pending, with no ready.
  - The ready pulse goes only to the granted master; the other master's rdata is unchanged.
  - Under saturation in round-robin mode, each master gets at most one access before the other.
  - A level-high ram_ready already present on entry to ACCESS is not completion; a new rising edge is required.

Decomposition:
- Shared package sdram_arb_pkg:
  - state encoding localparams (BLOCK/IDLE/ACCESS/DONE);
  - the wstrb-to-dqm conversion function;
  - master index constants.
- Sub-module sdram_rr_pick: combinational 2-way grant from {valid1, valid0}, last_grant and PRIORITY_MODE, producing grant_valid and grant_idx. It is reused by the top state machine only.

Test Plan:
- Reset, then m0 read at 0x000100; model asserts ram_ready for 2 cycles with dout=0x11223344 -> no ram_oe during the first 34 cycles; then ram_oe=1, ram_addr=0x000100; m0_ready pulses once with m0_rdata=0x11223344.
- m1 write, wstrb=4'b0011, wdata=0xAABBCCDD -> ram_we=1, ram_dqm=4'b1100, ram_din=0xAABBCCDD, held until the ready edge; m1_ready pulses once.
- Both valid continuously, PRIORITY_MODE=0 -> grants alternate m0,m1,m0,m1; with PRIORITY_MODE=1 -> m0 only while m0_valid holds.
- Continuous m0 traffic for 2000 cycles -> at least 3 BLOCK windows, each with ram_oe=ram_we=0 for 34 consecutive cycles, spaced no more than ~600 + access time.
- resetn asserted mid-ACCESS with model ready arriving 5 cycles later -> no m*_ready pulse; the stale ready edge is ignored; the next request completes normally after BLOCK.
- ram_ready held high entering ACCESS from the prior transfer -> no premature completion; completion only on the next rising edge.
